// File: rtl/digi_ota_pkg.sv
// -----------------------------------------------------------------------------
// digi_ota_pkg
// Shared types and helpers for the digital OTA array.
//   ota_state_e : hysteretic output stage state (OTA_LOW / OTA_HIGH)
//   ota_dec_e   : per-cycle comparison decision (DEC_HOLD / DEC_UP / DEC_DN)
//   midscale()  : accumulator midscale value 2^(acc_w-1)
// No ports (package).
// -----------------------------------------------------------------------------
package digi_ota_pkg;

  typedef enum logic {
    OTA_LOW  = 1'b0,
    OTA_HIGH = 1'b1
  } ota_state_e;

  typedef enum logic [1:0] {
    DEC_HOLD = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2
  } ota_dec_e;

  function automatic int midscale(input int acc_w);
    return 1 << (acc_w - 1);
  endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// -----------------------------------------------------------------------------
// digi_ota_chan
// One OTA channel: 2-FF input synchronisers, UP/DN/HOLD decision, saturating
// charge accumulator, two-state hysteretic output FSM and drive-enable.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : 1 = accumulator and FSM update, 0 = freeze
//   clear       : synchronous clear (acc = midscale, state = OTA_LOW)
//   leak_tick   : on a HOLD decision, move acc one step toward midscale
//   vip, vin    : asynchronous differential input pair
//   out         : hysteretic output level
//   drive_en    : registered (vip != vin) after synchronisation
//   acc         : current accumulator value
// -----------------------------------------------------------------------------
module digi_ota_chan
  import digi_ota_pkg::*;
#(
  parameter int ACC_W = 6,
  parameter int STEP  = 1,
  parameter int HYST  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic             leak_tick,
  input  logic             vip,
  input  logic             vin,
  output logic             out,
  output logic             drive_en,
  output logic [ACC_W-1:0] acc
);

  localparam int MID = midscale(ACC_W);

  // Wide (ACC_W+1) constants keep the saturation compares free of wrap-around.
  localparam logic [ACC_W:0]   ACC_MAX_X = (ACC_W+1)'((1 << ACC_W) - 1);
  localparam logic [ACC_W:0]   STEP_X    = (ACC_W+1)'(STEP);
  localparam logic [ACC_W:0]   MID_X     = (ACC_W+1)'(MID);
  localparam logic [ACC_W:0]   HI_TH_X   = (ACC_W+1)'(MID + HYST);
  localparam logic [ACC_W:0]   LO_TH_X   = (ACC_W+1)'(MID - HYST);
  localparam logic [ACC_W-1:0] ACC_MAX_N = ACC_W'((1 << ACC_W) - 1);
  localparam logic [ACC_W-1:0] STEP_N    = ACC_W'(STEP);
  localparam logic [ACC_W-1:0] MID_N     = ACC_W'(MID);
  localparam logic [ACC_W-1:0] ONE_N     = ACC_W'(1);

  logic [1:0]       vip_sync;
  logic [1:0]       vin_sync;
  ota_dec_e         dec;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   sum_x;
  ota_state_e       state_q;
  ota_state_e       state_d;
  logic             drive_q;

  // Synchronisers run unconditionally; ena only freezes acc and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vip_sync <= 2'b00;
      vin_sync <= 2'b00;
      drive_q  <= 1'b0;
    end else begin
      vip_sync <= {vip_sync[0], vip};
      vin_sync <= {vin_sync[0], vin};
      drive_q  <= (dec != DEC_HOLD);
    end
  end

  always_comb begin
    dec = DEC_HOLD;
    if (vip_sync[1] && !vin_sync[1]) begin
      dec = DEC_UP;
    end else if (!vip_sync[1] && vin_sync[1]) begin
      dec = DEC_DN;
    end
  end

  // Next accumulator value; clear beats ena, ena beats the decision.
  always_comb begin
    acc_x = {1'b0, acc_q};
    sum_x = acc_x + STEP_X;
    acc_d = acc_q;
    if (clear) begin
      acc_d = MID_N;
    end else if (ena) begin
      unique case (dec)
        DEC_UP: begin
          if (sum_x > ACC_MAX_X) begin
            acc_d = ACC_MAX_N;
          end else begin
            acc_d = sum_x[ACC_W-1:0];
          end
        end
        DEC_DN: begin
          if (acc_x < STEP_X) begin
            acc_d = '0;
          end else begin
            acc_d = acc_q - STEP_N;
          end
        end
        default: begin
          if (leak_tick) begin
            if (acc_x > MID_X) begin
              acc_d = acc_q - ONE_N;
            end else if (acc_x < MID_X) begin
              acc_d = acc_q + ONE_N;
            end
          end
        end
      endcase
    end
  end

  // Hysteresis looks at the registered accumulator, so out trails acc by one cycle.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = OTA_LOW;
    end else if (ena) begin
      unique case (state_q)
        OTA_LOW:  if (acc_x >= HI_TH_X) state_d = OTA_HIGH;
        OTA_HIGH: if (acc_x <= LO_TH_X) state_d = OTA_LOW;
        default:  state_d = OTA_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= MID_N;
      state_q <= OTA_LOW;
    end else begin
      acc_q   <= acc_d;
      state_q <= state_d;
    end
  end

  assign out      = (state_q == OTA_HIGH);
  assign drive_en = drive_q;
  assign acc      = acc_q;

endmodule

// File: rtl/digi_ota_array.sv
// -----------------------------------------------------------------------------
// digi_ota_array
// CHANNELS independent clocked digital OTA channels with a registered
// accumulator readout port.
// Optional feature macro: DIGI_OTA_LEAK_EN -- a LEAK_SH-bit free-running
// prescaler (runs while ena=1, reset by clear) pulls HOLD channels one step
// toward midscale each time it reaches all-ones. Without it LEAK_SH is unused.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : 1 = update accumulators/FSMs, 0 = freeze them
//   clear      : synchronous clear of every channel
//   vip, vin   : per-channel asynchronous input pairs
//   out        : per-channel hysteretic output
//   drive_en   : per-channel drive enable (vip != vin after sync)
//   rd_sel     : accumulator readout select
//   rd_data    : registered accumulator of channel rd_sel (0 if out of range)
// -----------------------------------------------------------------------------
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 6,
  parameter int STEP     = 1,
  parameter int HYST     = 4,
  parameter int LEAK_SH  = 3,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] drive_en,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [ACC_W-1:0]    rd_data
);

  logic             leak_tick;
  logic [ACC_W-1:0] acc_all [CHANNELS];
  logic [ACC_W-1:0] rd_mux;

`ifdef DIGI_OTA_LEAK_EN
  logic [LEAK_SH-1:0] presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (ena) begin
      presc_q <= presc_q + LEAK_SH'(1);
    end
  end

  assign leak_tick = ena && (&presc_q);
`else
  logic unused_leak_sh;
  assign unused_leak_sh = (LEAK_SH > 0);
  assign leak_tick      = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    digi_ota_chan #(
      .ACC_W (ACC_W),
      .STEP  (STEP),
      .HYST  (HYST)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .clear     (clear),
      .leak_tick (leak_tick),
      .vip       (vip[g]),
      .vin       (vin[g]),
      .out       (out[g]),
      .drive_en  (drive_en[g]),
      .acc       (acc_all[g])
    );
  end

  // A select that matches no channel falls through to the zero default.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_mux = acc_all[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux;
    end
  end

endmodule
